ripple_add_sequencer: RTL

Nibble-serial multi-precision adder controller that time-shares one 4-bit `rippleCarry` adder instance (ports A, B, Cin, Sum, Cout) to add operands of 4·NIBBLES bits. It latches both operands on a start request and feeds one nibble per clock through the adder, least-significant first, chaining the carry in a register. It returns the full-width sum, carry-out and signed overflow with a one-cycle done pulse. It is the sequencing layer above the 4-bit ripple-carry datapath for wider arithmetic without replicating adders.

---
 rtl/ripple_add_sequencer_if.sv | 32 +++
 rtl/ripple_add_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ripple_add_sequencer_if.sv
// Handshake/operand/result bundle for ripple_add_sequencer.
// The sub port exists only when SUB_ADDER_SEQ_SUB_EN is defined.
interface ripple_add_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SUB_ADDER_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

`ifdef SUB_ADDER_SEQ_SUB_EN
    modport master (output start, a, b, cin, sub,
                    input  busy, done, sum, cout, overflow);
    modport slave  (input  start, a, b, cin, sub,
                    output busy, done, sum, cout, overflow);
`else
    modport master (output start, a, b, cin,
                    input  busy, done, sum, cout, overflow);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, cout, overflow);
`endif
endinterface

// File: rtl/ripple_add_sequencer.sv
// Nibble-serial multi-precision adder sharing one 4-bit ripple-carry slice.
// Define SUB_ADDER_SEQ_SUB_EN to add the sub port (a - b via inverted b, carry-in 1).
module ripple_add_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input logic               clk,
    input logic               rst,
    ripple_add_sequencer_if.slave bus
);
    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     a_reg, b_reg, sum_r;
    logic [IDX_W-1:0] idx;
    logic             carry, busy_r, done_r, cout_r, ovf_r;
    logic [3:0]       a_nib, b_nib, add_sum;
    logic             add_cout, last_c;

    assign last_c = (idx == LAST_IDX);

    // Select the current slice of both operands.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    rippleCarry u_adder (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_c)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, slice write-back and carry chaining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            sum_r  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_nxt == RUN);
            done_r <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a;
`ifdef SUB_ADDER_SEQ_SUB_EN
                        b_reg  <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub ? 1'b1 : bus.cin;
`else
                        b_reg  <= bus.b;
                        carry  <= bus.cin;
`endif
                        idx    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < int'(NIBBLES); i++) begin
                        if (idx == IDX_W'(i)) sum_r[4*i +: 4] <= add_sum;
                    end
                    carry <= add_cout;
                    idx   <= idx + IDX_W'(1);
                    if (last_c) begin
                        cout_r <= add_cout;
                        // Top result bit is being written on this very edge.
                        ovf_r  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
endmodule

// Purely combinational 4-bit ripple-carry adder slice.
module rippleCarry (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]  = A[i] ^ B[i] ^ c[i];
            c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[4];
    end
endmodule
